// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_operand_stage
// Purpose : ID/EX pipeline register with MEM/WB operand forwarding for the ALU
// Revision: 1.0 - initial release
// ============================================================================
module id_ex_operand_stage #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [WIDTH-1:0]   id_rd1,
  input  logic [WIDTH-1:0]   id_rd2,
  input  logic [WIDTH-1:0]   id_signImm,
  input  logic [REGBITS-1:0] id_rs,
  input  logic [REGBITS-1:0] id_rt,
  input  logic [REGBITS-1:0] id_rd,
  input  logic [2:0]         id_aluCtrl,
  input  logic               id_aluSrc,
  input  logic               id_regDst,
  input  logic               id_regWrite,
  input  logic               id_memToReg,
  input  logic               id_memWrite,
  input  logic               mem_regWrite,
  input  logic [REGBITS-1:0] mem_writeReg,
  input  logic [WIDTH-1:0]   mem_aluRslt,
  input  logic               wb_regWrite,
  input  logic [REGBITS-1:0] wb_writeReg,
  input  logic [WIDTH-1:0]   wb_result,
  output logic [WIDTH-1:0]   srcA,
  output logic [WIDTH-1:0]   srcB,
  output logic [2:0]         aluCtrl,
  output logic [WIDTH-1:0]   ex_writeData,
  output logic [REGBITS-1:0] ex_writeReg,
  output logic               ex_regWrite,
  output logic               ex_memToReg,
  output logic               ex_memWrite,
  output logic               ex_valid
);

  localparam logic [REGBITS-1:0] C_REG_ZERO = '0;

  logic               r_valid;
  logic [WIDTH-1:0]   r_rd1;
  logic [WIDTH-1:0]   r_rd2;
  logic [WIDTH-1:0]   r_signImm;
  logic [REGBITS-1:0] r_rs;
  logic [REGBITS-1:0] r_rt;
  logic [REGBITS-1:0] r_rd;
  logic [2:0]         r_aluCtrl;
  logic               r_aluSrc;
  logic               r_regDst;
  logic               r_regWrite;
  logic               r_memToReg;
  logic               r_memWrite;

  logic [WIDTH-1:0]   w_fwdA;
  logic [WIDTH-1:0]   w_fwdB;

  // Flush outranks stall so a bubble can be injected while ID is held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n || flush) begin
      r_valid    <= 1'b0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_signImm  <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_aluCtrl  <= 3'b000;
      r_aluSrc   <= 1'b0;
      r_regDst   <= 1'b0;
      r_regWrite <= 1'b0;
      r_memToReg <= 1'b0;
      r_memWrite <= 1'b0;
    end else if (!stall) begin
      r_valid    <= id_valid;
      r_rd1      <= id_rd1;
      r_rd2      <= id_rd2;
      r_signImm  <= id_signImm;
      r_rs       <= id_rs;
      r_rt       <= id_rt;
      r_rd       <= id_rd;
      r_aluCtrl  <= id_aluCtrl;
      r_aluSrc   <= id_aluSrc;
      r_regDst   <= id_regDst;
      r_regWrite <= id_regWrite;
      r_memToReg <= id_memToReg;
      r_memWrite <= id_memWrite;
    end
  end

  // MEM is checked first because it carries the newer value; $zero never forwards.
  always_comb begin
    w_fwdA = r_rd1;
    if (mem_regWrite && (mem_writeReg == r_rs) && (r_rs != C_REG_ZERO))
      w_fwdA = mem_aluRslt;
    else if (wb_regWrite && (wb_writeReg == r_rs) && (r_rs != C_REG_ZERO))
      w_fwdA = wb_result;
  end

  always_comb begin
    w_fwdB = r_rd2;
    if (mem_regWrite && (mem_writeReg == r_rt) && (r_rt != C_REG_ZERO))
      w_fwdB = mem_aluRslt;
    else if (wb_regWrite && (wb_writeReg == r_rt) && (r_rt != C_REG_ZERO))
      w_fwdB = wb_result;
  end

  assign srcA         = w_fwdA;
  assign srcB         = r_aluSrc ? r_signImm : w_fwdB;
  assign ex_writeData = w_fwdB;
  assign aluCtrl      = r_aluCtrl;
  assign ex_writeReg  = r_regDst ? r_rd : r_rt;
  assign ex_regWrite  = r_regWrite;
  assign ex_memToReg  = r_memToReg;
  assign ex_memWrite  = r_memWrite;
  assign ex_valid     = r_valid;

endmodule
`default_nettype wire
